// File: rtl/regfile_pkg.sv
// +------------------------------------------------------------------+
// | regfile_pkg : shared defaults and index type for regfile_mp  r1.0 |
// +------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;
  localparam int REGFILE_WIDTH    = 16;
  localparam int REGFILE_NUM_REGS = 16;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

`default_nettype wire

// File: rtl/regfile_word.sv
// +------------------------------------------------------------------+
// | regfile_word : WIDTH-bit storage word, write enable, sync reset  r1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// +------------------------------------------------------------------+
// | regfile_mp : multi-read-port register file with busy scoreboard  r1.0 |
// | Optional REGFILE_BYPASS_EN forwards same-cycle writeback to reads.   |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic [NUM_REGS-1:0]     busy_vec
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;

  assign regs[0] = '0;

  genvar i;
  generate
    for (i = 1; i < NUM_REGS; i++) begin : g_word
      logic wen;
      assign wen = wr_en && (wr_addr == AW'(i));

      regfile_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk (clk),
        .rst (rst),
        .wen (wen),
        .d   (wr_data),
        .q   (regs[i])
      );
    end
  endgenerate

  // Clear before set so a same-edge issue to the written register wins.
  always_comb begin
    busy_next = busy_vec;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (iss_en && (iss_addr != AW'(ZERO_REG))) begin
      busy_next[iss_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic fwd;
      assign fwd = wr_en && (wr_addr == ra) && (ra != AW'(ZERO_REG));
      assign rd_data[k*WIDTH +: WIDTH] = fwd ? wr_data : regs[ra];
      assign rd_busy[k]                = fwd ? 1'b0 : busy_vec[ra];
`else
      assign rd_data[k*WIDTH +: WIDTH] = regs[ra];
      assign rd_busy[k]                = busy_vec[ra];
`endif
    end
  endgenerate

endmodule

`default_nettype wire
